// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

    // Operands narrower than 4 digits are zero-extended, so unused nibbles never flag.
    function automatic logic bcd_has_bad_digit(input logic [15:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] > BCD_MAX_DIGIT) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_digit_adj.sv
// One BCD digit correction step for reverse double-dabble: subtract 3 when >= 8.
module bcd_digit_adj
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit - BCD_ADJ) : i_digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble with a start/busy/done handshake.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BCD_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BCD_W - 1);

    state_t                 r_state;
    logic [BCD_W-1:0]       r_bcd;
    logic [BCD_W-1:0]       r_bin;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIN_W-1:0]       r_bin_out;
    logic                   r_err;

    logic [2*BCD_W-1:0]     w_shift;
    logic [BCD_W-1:0]       w_bcd_sh;
    logic [BCD_W-1:0]       w_bcd_adj;
    logic [BCD_W-1:0]       w_bin_sh;
    logic [BIN_W-1:0]       w_result;
    logic                   w_bad;

    assign w_shift  = {r_bcd, r_bin} >> 1;
    assign w_bcd_sh = w_shift[2*BCD_W-1:BCD_W];
    assign w_bin_sh = w_shift[BCD_W-1:0];
    assign w_bad    = bcd_has_bad_digit(16'(bcd_in));

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (w_bcd_sh[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    // Result is the post-final-shift value; widen or truncate to BIN_W losslessly.
    if (BIN_W <= BCD_W) begin : g_trunc
        assign w_result = w_bin_sh[BIN_W-1:0];
    end else begin : g_ext
        assign w_result = {{(BIN_W-BCD_W){1'b0}}, w_bin_sh};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bcd <= bcd_in;
                        r_bin <= '0;
                        r_cnt <= '0;
                        if (w_bad) begin
                            r_err     <= 1'b1;
                            r_bin_out <= '0;
                            r_state   <= ST_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_bin <= w_bin_sh;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_SHIFT) begin
                        r_bin_out <= w_result;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bin_out = r_bin_out;
    assign err     = r_err;
    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq (DIGITS=2, BIN_W=7): stimulus pushes expectations, monitor pops on done.
module tb_bcd_to_bin_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bcd_in;
    logic [6:0] bin_out;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    typedef struct {
        logic [6:0]  bin;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done cyc=%0d bin_out=%0d err=%0b required no done pulse",
                         cyc, bin_out, err);
            end else begin
                e = sb.pop_front();
                if (bin_out !== e.bin || err !== e.err || cyc != e.due) begin
                    miscompares++;
                    $display("FAIL result got bin_out=%0d err=%0b cyc=%0d required bin_out=%0d err=%0b cyc=%0d",
                             bin_out, err, cyc, e.bin, e.err, e.due);
                end
            end
        end
    end

    function automatic logic [7:0] ref_conv(input logic [7:0] b);
        int unsigned hi;
        int unsigned lo;
        hi = int'(b[7:4]);
        lo = int'(b[3:0]);
        if (hi > 9 || lo > 9) return 8'h80;
        return {1'b0, 7'(hi * 10 + lo)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    // Called at a negedge; waits for IDLE, presents one start pulse, returns at the next negedge.
    task automatic issue(input logic [7:0] b, input logic [6:0] eb, input logic ee, input bit push);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout busy=%0b required 0", busy);
        end
        start  = 1'b1;
        bcd_in = b;
        if (push) sb.push_back('{bin: eb, err: ee, due: (ee ? cyc + 1 : cyc + 9)});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bc;
        int unsigned c;
        logic [7:0]  b;
        logic [7:0]  r;

        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_bin_out", 32'(bin_out), 32'd0);
        chk("reset_busy",    32'(busy),    32'd0);
        chk("reset_done",    32'(done),    32'd0);
        chk("reset_err",     32'(err),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 99 also measures the busy window
        issue(8'h99, 7'd99, 1'b0, 1'b1);
        bc = 0;
        for (int k = 0; k < 30; k++) begin
            if (!busy) break;
            bc++;
            @(negedge clk);
        end
        chk("busy_cycles_99", 32'(bc), 32'd9);

        issue(8'h00, 7'd0,  1'b0, 1'b1);
        issue(8'h15, 7'd15, 1'b0, 1'b1);
        issue(8'h3A, 7'd0,  1'b1, 1'b1);
        issue(8'h42, 7'd42, 1'b0, 1'b1);
        issue(8'hA0, 7'd0,  1'b1, 1'b1);
        issue(8'h90, 7'd90, 1'b0, 1'b1);
        drain();

        // Re-pulse with a new operand mid-conversion: must be ignored
        issue(8'h27, 7'd27, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bcd_in = 8'h11;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 8'h00;
        drain();
        chk("hold_bin_out_27", 32'(bin_out), 32'd27);

        // Reset during shift 4 of 58 aborts with no done pulse
        issue(8'h58, 7'd58, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_bin_out", 32'(bin_out), 32'd0);
        chk("midrst_busy",    32'(busy),    32'd0);
        chk("midrst_done",    32'(done),    32'd0);
        chk("midrst_err",     32'(err),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        issue(8'h58, 7'd58, 1'b0, 1'b1);
        drain();

        // Start held high: one conversion every 10 cycles
        c = cyc;
        sb.push_back('{bin: 7'd64, err: 1'b0, due: c + 9});
        sb.push_back('{bin: 7'd64, err: 1'b0, due: c + 19});
        sb.push_back('{bin: 7'd64, err: 1'b0, due: c + 29});
        start  = 1'b1;
        bcd_in = 8'h64;
        repeat (25) @(negedge clk);
        start = 1'b0;
        drain();

        // Full valid sweep against the decimal reference
        for (int t = 0; t < 10; t++) begin
            for (int u = 0; u < 10; u++) begin
                b = {4'(t), 4'(u)};
                r = ref_conv(b);
                issue(b, r[6:0], r[7], 1'b1);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
